// File: rtl/adc_spi_pkg.sv
// Shared types and default constants for the ADC SPI frame controller.
// Holds the FSM state enum and the default frame geometry.
// Optional macro used by the top: ADC_SPI_DONE_PULSE_EN (adds a done pulse output).
package adc_spi_pkg;

  // FSM states: idle, command shift-out, sample read window, chip-select high hold
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_READ = 2'd2,
    ST_HOLD = 2'd3
  } adc_spi_state_t;

  // Default frame geometry: start, single-ended, channel 0, MSB-first format
  localparam int         DEF_CMD_BITS       = 4;
  localparam logic [3:0] DEF_CMD            = 4'b1101;
  localparam int         DEF_READ_BITS      = 12;
  localparam int         DEF_CS_HIGH_CYCLES = 2;

  // Counter width able to hold (count-1) for the largest of the three phases
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    int w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    w = $clog2(m);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/adc_spi_cmd_shreg.sv
// Parallel-load, MSB-first shift register holding the ADC command word.
// Latency: load/shift take effect on the next rising edge; next_bit is combinational from the register.
// Backpressure: none; load has priority over shift, both are single-cycle strobes from the FSM.
module adc_spi_cmd_shreg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] load_val,
  output logic         next_bit
);

  logic [W-1:0] q;
  logic [W-1:0] q_shifted;

  // The bit that will sit at the MSB after the next shift is the one the FSM presents next
  assign q_shifted = q << 1;
  assign next_bit  = q_shifted[W-1];

  // Load the command word at frame start, then move one bit toward the MSB per command cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= q_shifted;
    end
  end

endmodule

// File: rtl/adc_spi_fsm.sv
// Frames one ADC conversion per start_read: chip_en low, command bits out on sdo, then a reading window.
// Latency: chip_en/sdo change on the edge sampling start_read; frame is CMD_BITS+READ_BITS cycles plus CS_HIGH_CYCLES hold.
// Backpressure: start_read is ignored while busy (not queued), except a held request restarts on the final hold edge.
// Optional macro ADC_SPI_DONE_PULSE_EN adds a one-cycle registered done pulse coincident with chip_en rising.
module adc_spi_fsm
  import adc_spi_pkg::*;
#(
  parameter int                  CMD_BITS       = DEF_CMD_BITS,
  parameter logic [CMD_BITS-1:0] CMD            = CMD_BITS'(DEF_CMD),
  parameter int                  READ_BITS      = DEF_READ_BITS,
  parameter int                  CS_HIGH_CYCLES = DEF_CS_HIGH_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic start_read,
`ifdef ADC_SPI_DONE_PULSE_EN
  output logic done,
`endif
  output logic sdo,
  output logic reading,
  output logic chip_en
);

  localparam int              CNT_W     = cnt_width(CMD_BITS, READ_BITS, CS_HIGH_CYCLES);
  localparam logic [CNT_W-1:0] CMD_LOAD  = CNT_W'(CMD_BITS - 1);
  localparam logic [CNT_W-1:0] READ_LOAD = CNT_W'(READ_BITS - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(CS_HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  adc_spi_state_t   state;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             frame_start;
  logic             shift_en;
  logic             cmd_next_bit;

  assign cnt_zero = (cnt == '0);

  // A frame starts from IDLE, or directly out of the last HOLD cycle when the request is still held
  assign frame_start = start_read &&
                       ((state == ST_IDLE) || ((state == ST_HOLD) && cnt_zero));

  // Advance the command word on every CMD cycle except the one that leaves for READ
  assign shift_en = (state == ST_CMD) && !cnt_zero;

  adc_spi_cmd_shreg #(
    .W (CMD_BITS)
  ) u_cmd_shreg (
    .clk      (clk),
    .reset    (reset),
    .load     (frame_start),
    .shift    (shift_en),
    .load_val (CMD),
    .next_bit (cmd_next_bit)
  );

  // Frame sequencer: owns the phase counter and drives all outputs from registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      chip_en <= 1'b1;
      sdo     <= 1'b0;
      reading <= 1'b0;
`ifdef ADC_SPI_DONE_PULSE_EN
      done    <= 1'b0;
`endif
    end else begin
`ifdef ADC_SPI_DONE_PULSE_EN
      done <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            state   <= ST_CMD;
            chip_en <= 1'b0;
            sdo     <= CMD[CMD_BITS-1];
            cnt     <= CMD_LOAD;
          end
        end

        ST_CMD: begin
          if (cnt_zero) begin
            // CMD[0] has been on the wire for a full cycle; open the sample window
            state   <= ST_READ;
            sdo     <= 1'b0;
            reading <= 1'b1;
            cnt     <= READ_LOAD;
          end else begin
            sdo <= cmd_next_bit;
            cnt <= cnt - CNT_ONE;
          end
        end

        ST_READ: begin
          if (cnt_zero) begin
            state   <= ST_HOLD;
            reading <= 1'b0;
            chip_en <= 1'b1;
            cnt     <= HOLD_LOAD;
`ifdef ADC_SPI_DONE_PULSE_EN
            done    <= 1'b1;
`endif
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        ST_HOLD: begin
          if (cnt_zero) begin
            if (frame_start) begin
              // Back-to-back request: chip_en has met its minimum high time
              state   <= ST_CMD;
              chip_en <= 1'b0;
              sdo     <= CMD[CMD_BITS-1];
              cnt     <= CMD_LOAD;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        default: begin
          state   <= ST_IDLE;
          chip_en <= 1'b1;
          sdo     <= 1'b0;
          reading <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_fsm.sv
// Scoreboard bench for adc_spi_fsm: stimulus pushes expected outputs, a monitor pops and compares.
// Expected frame shape is built from the default geometry (4 command bits 1101, 12 read cycles, 2 hold cycles).
// Define ADC_SPI_DONE_PULSE_EN to also compare the done pulse.
module tb_adc_spi_fsm;

  logic clk;
  logic reset;
  logic start_read;
  logic sdo;
  logic reading;
  logic chip_en;
  logic done;

  int checks;
  int errors;

  // expected vector: {done, chip_en, sdo, reading}
  logic [3:0] exp_q[$];
  logic [3:0] idle_v;
  logic [3:0] cmd_word;

  adc_spi_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .start_read (start_read),
`ifdef ADC_SPI_DONE_PULSE_EN
    .done       (done),
`endif
    .sdo        (sdo),
    .reading    (reading),
    .chip_en    (chip_en)
  );

`ifndef ADC_SPI_DONE_PULSE_EN
  assign done = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  // Expected outputs after the k-th edge of a frame (k = 0 is the edge sampling start_read)
  function automatic logic [3:0] model(input int k);
    if (k < 4)       return {1'b0, 1'b0, cmd_word[3-k], 1'b0};
    else if (k < 16) return 4'b0001;
    else if (k == 16) return 4'b1100;
    else             return 4'b0100;
  endfunction

  // One clock: drive inputs away from the active edge, then post the expectation for after the edge
  task automatic cyc(input logic s, input logic r, input logic [3:0] e);
    @(negedge clk);
    start_read = s;
    reset      = r;
    @(posedge clk);
    #1;
    exp_q.push_back(e);
  endtask

  // One full frame of 18 edges; an optional extra start_read pulse at edge busy_at
  task automatic frame(input int busy_at);
    for (int k = 0; k < 18; k++) begin
      cyc((k == 0) || (k == busy_at), 1'b1, model(k));
    end
  endtask

  // Monitor: compare every cycle for which an expectation is pending
  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("chip_en", chip_en, e[2]);
        check("sdo",     sdo,     e[1]);
        check("reading", reading, e[0]);
`ifdef ADC_SPI_DONE_PULSE_EN
        check("done",    done,    e[3]);
`endif
      end
    end
  end

  initial begin
    checks     = 0;
    errors     = 0;
    idle_v     = 4'b0100;
    cmd_word   = 4'b1101;
    reset      = 1'b0;
    start_read = 1'b1;

    // Reset held with start_read high: stays idle
    cyc(1'b1, 1'b0, idle_v);
    cyc(1'b1, 1'b0, idle_v);
    cyc(1'b0, 1'b1, idle_v);

    // Single frame, then idle
    frame(-1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, idle_v);

    // Busy ignore: second request 5 cycles in changes nothing and is not queued
    frame(5);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, idle_v);

    // Back-to-back: held request gives an 18-cycle period with 2 chip_en-high cycles
    for (int j = 0; j < 54; j++) cyc(1'b1, 1'b1, model(j % 18));
    cyc(1'b0, 1'b1, idle_v);
    cyc(1'b0, 1'b1, idle_v);

    // Mid-frame reset during READ: outputs go idle asynchronously
    for (int k = 0; k < 8; k++) cyc(k == 0, 1'b1, model(k));
    @(posedge clk);
    #2;
    check("pre_rst_reading", reading, 1'b1);
    reset = 1'b0;
    #1;
    check("async_rst_chip_en", chip_en, 1'b1);
    check("async_rst_reading", reading, 1'b0);
    check("async_rst_sdo",     sdo,     1'b0);
    cyc(1'b0, 1'b0, idle_v);
    cyc(1'b0, 1'b1, idle_v);
    cyc(1'b0, 1'b1, idle_v);

    // A fresh frame after reset release proves IDLE was entered
    frame(-1);
    cyc(1'b0, 1'b1, idle_v);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
